// File: rtl/bool_pkg.sv
// Shared constants and types for the boolean scheduler: data width, opcode
// encodings, the result-slot state type and an opcode legality helper.
package bool_pkg;

   localparam int W = 32;

   localparam logic [3:0] OP_PASS = 4'b1010;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b1110;
   localparam logic [3:0] OP_XNOR = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b0110;

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_PASS, OP_AND, OP_NOR, OP_OR, OP_XNOR, OP_XOR: return 1'b1;
         default:                                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bool_sched_bool.sv
// Combinational boolean unit: applies one of six bitwise functions to A and B;
// any unrecognised opcode passes A through unchanged.
module bool #(
   parameter int W = bool_pkg::W
) (
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   import bool_pkg::*;

   always_comb begin
      y = a;
      case (op)
         OP_PASS: y = a;
         OP_AND:  y = a & b;
         OP_NOR:  y = ~(a | b);
         OP_OR:   y = a | b;
         OP_XNOR: y = ~(a ^ b);
         OP_XOR:  y = a ^ b;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/bool_sched.sv
// Two-requester round-robin front end for the boolean unit with a single
// registered result slot. Define BOOL_SCHED_OPCHK_EN to flag illegal opcodes on rsp_err.
//
// state | meaning
// IDLE  | no result held
// FULL  | result held, rsp_valid=1
module bool_sched #(
   parameter int W         = bool_pkg::W,
   parameter int INIT_PRIO = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid_0,
   output logic         req_ready_0,
   input  logic [3:0]   req_op_0,
   input  logic [W-1:0] req_a_0,
   input  logic [W-1:0] req_b_0,
   input  logic         req_valid_1,
   output logic         req_ready_1,
   input  logic [3:0]   req_op_1,
   input  logic [W-1:0] req_a_1,
   input  logic [W-1:0] req_b_1,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_id,
   output logic         rsp_err,
   output logic [15:0]  op_count
);
   import bool_pkg::*;

   state_t       state;
   logic         prio;
   logic         slot_free;
   logic         gnt_0;
   logic         gnt_1;
   logic         accept;
   logic [3:0]   sel_op;
   logic [W-1:0] sel_a;
   logic [W-1:0] sel_b;
   logic [W-1:0] result;

   // A held result that is being consumed this cycle frees the slot for a back-to-back accept.
   assign slot_free = (state == IDLE) || rsp_ready;

   assign gnt_0 = req_valid_0 && (!req_valid_1 || (prio == 1'b0));
   assign gnt_1 = req_valid_1 && (!req_valid_0 || (prio == 1'b1));

   assign req_ready_0 = rst_n && slot_free && gnt_0;
   assign req_ready_1 = rst_n && slot_free && gnt_1;
   assign accept      = req_ready_0 || req_ready_1;

   assign sel_op = req_ready_1 ? req_op_1 : req_op_0;
   assign sel_a  = req_ready_1 ? req_a_1  : req_a_0;
   assign sel_b  = req_ready_1 ? req_b_1  : req_b_0;

   bool #(.W(W)) u_bool (
      .op (sel_op),
      .a  (sel_a),
      .b  (sel_b),
      .y  (result)
   );

   assign rsp_valid = (state == FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         prio     <= 1'(INIT_PRIO);
         rsp_data <= '0;
         rsp_id   <= 1'b0;
         op_count <= 16'd0;
      end else if (accept) begin
         state    <= FULL;
         prio     <= ~req_ready_1;
         rsp_data <= result;
         rsp_id   <= req_ready_1;
         op_count <= op_count + 16'd1;
      end else if ((state == FULL) && rsp_ready) begin
         state    <= IDLE;
      end
   end

`ifdef BOOL_SCHED_OPCHK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= ~op_legal(sel_op);
      end
   end

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

endmodule
